// File: rtl/debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
//
// One debounce channel. The filtered level (dout) only follows the raw input
// (din) after din has disagreed with dout for STABLE_CYCLES consecutive
// enabled clock edges. Any enabled edge where din agrees with dout throws away
// the count collected so far, so a bounce restarts the qualification window.
//
// Parameters:
//   STABLE_CYCLES  enabled edges of disagreement needed to flip dout (1..255)
//   RESET_BIT      value loaded into dout on reset
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset, wins over ena
//   ena   in   clock enable; when low, dout and the counter hold and pulses clear
//   din   in   synchronized raw input bit
//   dout  out  debounced level (registered)
//   rise  out  one-cycle pulse on the edge where dout goes 0->1 (registered)
//   fall  out  one-cycle pulse on the edge where dout goes 1->0 (registered)
// -----------------------------------------------------------------------------
module debounce_bit #(
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_BIT     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    // Counter wide enough to hold STABLE_CYCLES; it never exceeds
    // STABLE_CYCLES-1 because reaching that value with a further disagreement
    // commits the change and clears the count.
    localparam int            CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_BIT;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else if (ena) begin
            if (din == dout) begin
                // Input agrees with the filtered level: any pending change is
                // abandoned, no partial credit survives.
                cnt  <= '0;
                rise <= 1'b0;
                fall <= 1'b0;
            end else if (cnt == CNT_LAST) begin
                // This is the STABLE_CYCLES-th consecutive disagreement:
                // commit the new level and pulse in the same cycle.
                dout <= din;
                cnt  <= '0;
                rise <= din;
                fall <= ~din;
            end else begin
                cnt  <= cnt + 1'b1;
                rise <= 1'b0;
                fall <= 1'b0;
            end
        end else begin
            // Disabled edge: level and count hold, pulses are suppressed.
            rise <= 1'b0;
            fall <= 1'b0;
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Per-bit debounce filter for an already-synchronized switch/button bus.
// Each bit is an independent debounce_bit channel; all channels share the
// clock, reset and enable so they advance in lockstep. Every output is a
// flop, so nothing on data_in reaches the outputs combinationally.
//
// Parameters:
//   WIDTH          number of independent input bits
//   STABLE_CYCLES  enabled edges of disagreement needed to change a bit (1..255)
//   RESET_VALUE    value loaded into data_out on reset
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset, wins over ena
//   ena       in   clock enable; when low all state holds and pulses are 0
//   data_in   in   [WIDTH] synchronized raw inputs
//   data_out  out  [WIDTH] debounced levels
//   rise      out  [WIDTH] one-cycle pulse per bit on a 0->1 change of data_out
//   fall      out  [WIDTH] one-cycle pulse per bit on a 1->0 change of data_out
// -----------------------------------------------------------------------------
module input_debouncer #(
    parameter int               WIDTH         = 4,
    parameter int               STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_BIT     (RESET_VALUE[i])
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .ena  (ena),
            .din  (data_in[i]),
            .dout (data_out[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//
// Directed bench for input_debouncer. Main instance: WIDTH=4, STABLE_CYCLES=4,
// RESET_VALUE=0. A second instance with STABLE_CYCLES=1, RESET_VALUE=4'h3
// shares the same inputs and covers the one-cycle-follow case.
// Inputs change #1 after a rising edge; outputs are sampled #1 after the edge.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [3:0] data_in;
    logic [3:0] data_out, rise, fall;
    logic [3:0] data_out1, rise1, fall1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    input_debouncer #(
        .WIDTH         (4),
        .STABLE_CYCLES (4),
        .RESET_VALUE   (4'h0)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .data_in  (data_in),
        .data_out (data_out),
        .rise     (rise),
        .fall     (fall)
    );

    input_debouncer #(
        .WIDTH         (4),
        .STABLE_CYCLES (1),
        .RESET_VALUE   (4'h3)
    ) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .data_in  (data_in),
        .data_out (data_out1),
        .rise     (rise1),
        .fall     (fall1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [3:0] e_out,
                              input logic [3:0] e_rise, input logic [3:0] e_fall);
        check({tag, ".out"},  {28'd0, data_out}, {28'd0, e_out});
        check({tag, ".rise"}, {28'd0, rise},     {28'd0, e_rise});
        check({tag, ".fall"}, {28'd0, fall},     {28'd0, e_fall});
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        ena     = 1'b1;
        data_in = 4'h0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n_rise;
        logic [7:0] bounce;
        logic [5:0] ena_pat;

        // ---------------- reset ----------------
        rst     = 1'b1;
        ena     = 1'b1;
        data_in = 4'hF;
        for (int k = 0; k < 2; k++) begin
            step();
            check_main($sformatf("reset%0d", k), 4'h0, 4'h0, 4'h0);
            check($sformatf("reset%0d.out1", k), {28'd0, data_out1}, 32'h3);
            check($sformatf("reset%0d.pulse1", k), {24'd0, rise1, fall1}, 32'h0);
        end
        rst     = 1'b0;
        data_in = 4'h0;
        step();
        check_main("idle", 4'h0, 4'h0, 4'h0);
        // STABLE_CYCLES=1: 3 -> 0 on the first enabled edge, both bits fall.
        check("idle.out1",  {28'd0, data_out1}, 32'h0);
        check("idle.fall1", {28'd0, fall1},     32'h3);
        check("idle.rise1", {28'd0, rise1},     32'h0);

        // ---------------- clean rise on bit 0 ----------------
        data_in = 4'h1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_main($sformatf("clean_e%0d", k), 4'h0, 4'h0, 4'h0);
            if (k == 1) begin
                check("clean.out1",  {28'd0, data_out1}, 32'h1);
                check("clean.rise1", {28'd0, rise1},     32'h1);
            end
            if (k == 2) check("clean.rise1_off", {28'd0, rise1}, 32'h0);
        end
        step();
        check_main("clean_e4", 4'h1, 4'h1, 4'h0);
        step();
        check_main("clean_e5", 4'h1, 4'h0, 4'h0);

        // ---------------- bounce on bit 1 ----------------
        bounce = 8'b1111_0111;  // applied LSB first: 1,1,1,0,1,1,1,1
        n_rise = 0;
        for (int k = 0; k < 8; k++) begin
            data_in = {2'b00, bounce[k], 1'b1};
            step();
            n_rise += int'(rise[1]);
            if (k < 7) check($sformatf("bounce_e%0d.out", k + 1), {28'd0, data_out}, 32'h1);
        end
        check_main("bounce_e8", 4'h3, 4'h2, 4'h0);
        check("bounce.n_rise", n_rise, 32'd1);
        step();
        check_main("bounce_e9", 4'h3, 4'h0, 4'h0);

        // ---------------- ena gating ----------------
        do_reset();
        step();
        ena_pat = 6'b111001;    // applied LSB first: 1,0,0,1,1,1
        data_in = 4'h2;
        for (int k = 0; k < 6; k++) begin
            ena = ena_pat[k];
            step();
            if (k < 5) check_main($sformatf("gate_e%0d", k + 1), 4'h0, 4'h0, 4'h0);
        end
        check_main("gate_e6", 4'h2, 4'h2, 4'h0);
        ena = 1'b0;
        step();
        check_main("gate_off", 4'h2, 4'h0, 4'h0);
        ena = 1'b1;

        // ---------------- simultaneous rise/fall ----------------
        data_in = 4'hA;
        for (int k = 0; k < 4; k++) step();
        check_main("sim_setup", 4'hA, 4'h8, 4'h0);
        data_in = 4'h5;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_main($sformatf("sim_e%0d", k), 4'hA, 4'h0, 4'h0);
        end
        step();
        check_main("sim_e4", 4'h5, 4'h5, 4'hA);
        step();
        check_main("sim_e5", 4'h5, 4'h0, 4'h0);

        // ---------------- reset mid-count ----------------
        do_reset();
        step();
        data_in = 4'h8;
        step();
        step();
        rst = 1'b1;
        step();
        check_main("midrst", 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_main($sformatf("midrst_e%0d", k), 4'h0, 4'h0, 4'h0);
        end
        step();
        check_main("midrst_e4", 4'h8, 4'h8, 4'h0);

        // ---------------- clean fall on bit 3 ----------------
        data_in = 4'h0;
        for (int k = 0; k < 3; k++) step();
        check_main("fall_e3", 4'h8, 4'h0, 4'h0);
        step();
        check_main("fall_e4", 4'h0, 4'h0, 4'h8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
